// File: rtl/fechadura_pkg.sv
// rtl/fechadura_pkg.sv - shared types and constants for the door lock controller
package fechadura_pkg;

  localparam int N_DIG_DEF = 20;

  typedef logic [4*N_DIG_DEF-1:0] senha_t;

  localparam senha_t SENHA_VAZIA    = '1;
  localparam senha_t MASTER_DEFAULT = {{(4*N_DIG_DEF-16){1'b1}}, 16'h1234};

  typedef enum logic [2:0] {
    TRANCADA,
    VALIDAR,
    BLOQUEADO,
    NP,
    DESTRANCADA,
    ABERTA,
    BIPANDO,
    SETUP
  } estado_t;

  typedef struct packed {
    logic       bip_en;
    logic [7:0] bip_time;
    logic [7:0] tranca_time;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = '{bip_en: 1'b1, bip_time: 8'd5, tranca_time: 8'd5};

  // A zero time would expire on the first tick; treat it as one second.
  function automatic logic [7:0] no_zero(input logic [7:0] t);
    return (t == 8'd0) ? 8'd1 : t;
  endfunction

endpackage

// File: rtl/fechadura_if.sv
// rtl/fechadura_if.sv - password entry and setup write bus
interface fechadura_if #(
  parameter int N_SLOTS = 4,
  parameter int N_DIG   = 20
);
  localparam int SW = $clog2(N_SLOTS + 1);

  logic [4*N_DIG-1:0] senha_in;
  logic               senha_valid;
  logic               cfg_we;
  logic [SW-1:0]      cfg_slot;
  logic [4*N_DIG-1:0] cfg_senha;
  logic               cfg_bip_en;
  logic [7:0]         cfg_bip_time;
  logic [7:0]         cfg_tranca_time;
  logic               cfg_done;

  modport master (
    output senha_in, senha_valid, cfg_we, cfg_slot, cfg_senha,
           cfg_bip_en, cfg_bip_time, cfg_tranca_time, cfg_done
  );

  modport slave (
    input senha_in, senha_valid, cfg_we, cfg_slot, cfg_senha,
          cfg_bip_en, cfg_bip_time, cfg_tranca_time, cfg_done
  );
endinterface

// File: rtl/fechadura_senha_cmp.sv
// rtl/fechadura_senha_cmp.sv - parallel compare of one entry against master and user slots
module senha_cmp #(
  parameter int N_SLOTS = 4,
  parameter int N_DIG   = 20
) (
  input  logic [4*N_DIG-1:0] entrada,
  input  logic [4*N_DIG-1:0] master,
  input  logic [4*N_DIG-1:0] slots [N_SLOTS],
  output logic               match_any,
  output logic               match_master
);
  localparam int W = 4 * N_DIG;

  logic               vazia;
  logic [N_SLOTS-1:0] hit;

  // An all-F entry is never a valid password, and an all-F slot is disabled.
  assign vazia = (entrada == {W{1'b1}});

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      hit[i] = (slots[i] != {W{1'b1}}) && (slots[i] == entrada);
    end
  end

  assign match_master = !vazia && (entrada == master);
  assign match_any    = match_master || (!vazia && (|hit));

endmodule

// File: rtl/fechadura_ctrl_n.sv
// rtl/fechadura_ctrl_n.sv - door lock controller: state machine, timers, password store, lockout
module fechadura_ctrl_n
  import fechadura_pkg::*;
#(
  parameter int N_SLOTS  = 4,
  parameter int N_DIG    = 20,
  parameter int MAX_TENT = 5,
  parameter int T_BLOQ_S = 30,
  parameter int MAX_ESC  = 3,
  parameter int TICKS_S  = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sensor_contato,
  input  logic                          botao_interno,
  input  logic                          botao_bloqueio,
  input  logic                          botao_config,
  fechadura_if.slave                    bus,
  output logic                          tranca,
  output logic                          bip,
  output logic                          teclado_en,
  output logic                          display_en,
  output logic                          setup_on,
  output logic                          bloqueado,
  output logic [$clog2(MAX_TENT+1)-1:0] tent_rest
);
  localparam int W     = 4 * N_DIG;
  localparam int SW    = $clog2(N_SLOTS + 1);
  localparam int TW    = $clog2(MAX_TENT + 1);
  localparam int EW    = (MAX_ESC > 0) ? $clog2(MAX_ESC + 1) : 1;
  localparam int PW    = (TICKS_S > 1) ? $clog2(TICKS_S) : 1;
  localparam int SEC_W = 16;

  localparam logic [W-1:0] VAZIA      = {W{SENHA_VAZIA[0]}};
  localparam logic [W-1:0] MASTER_INI = {{(W-16){1'b1}}, MASTER_DEFAULT[15:0]};

  estado_t          state, next;
  logic [W-1:0]     entrada, master;
  logic [W-1:0]     slots [N_SLOTS];
  cfg_t             cfg;
  logic [EW-1:0]    esc;
  logic             flag_cfg;
  logic [PW-1:0]    presc;
  logic [SEC_W-1:0] secs, limit;
  logic             sec_tick, expired, match_any, match_master;

  senha_cmp #(.N_SLOTS(N_SLOTS), .N_DIG(N_DIG)) u_cmp (
    .entrada      (entrada),
    .master       (master),
    .slots        (slots),
    .match_any    (match_any),
    .match_master (match_master)
  );

  assign sec_tick = (presc == PW'(TICKS_S - 1));

  always_comb begin
    limit = '1;
    case (state)
      DESTRANCADA: limit = SEC_W'(cfg.tranca_time);
      ABERTA:      limit = SEC_W'(cfg.bip_time);
      BLOQUEADO:   limit = SEC_W'(T_BLOQ_S) << esc;
      default:     limit = '1;
    endcase
  end

  assign expired = sec_tick && ((secs + SEC_W'(1)) >= limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= TRANCADA;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      TRANCADA: begin
        if (botao_interno)        next = DESTRANCADA;
        else if (bus.senha_valid) next = VALIDAR;
        else if (botao_bloqueio)  next = NP;
      end
      VALIDAR: begin
        if (match_any)                      next = (flag_cfg && match_master) ? SETUP : DESTRANCADA;
        else if (tent_rest == TW'(1))       next = BLOQUEADO;
        else                                next = TRANCADA;
      end
      BLOQUEADO: begin
        if (botao_interno) next = DESTRANCADA;
        else if (expired)  next = TRANCADA;
      end
      NP: begin
        if (botao_interno)       next = DESTRANCADA;
        else if (botao_bloqueio) next = TRANCADA;
      end
      DESTRANCADA: begin
        if (!sensor_contato) next = ABERTA;
        else if (expired)    next = TRANCADA;
      end
      ABERTA: begin
        if (sensor_contato)             next = DESTRANCADA;
        else if (expired && cfg.bip_en) next = BIPANDO;
      end
      BIPANDO: if (sensor_contato) next = DESTRANCADA;
      SETUP:   if (bus.cfg_done)   next = DESTRANCADA;
      default: next = TRANCADA;
    endcase
  end

  always_comb begin
    tranca     = 1'b1;
    bip        = 1'b0;
    teclado_en = 1'b1;
    display_en = 1'b1;
    setup_on   = 1'b0;
    bloqueado  = 1'b0;
    case (state)
      BLOQUEADO:           begin teclado_en = 1'b0; bloqueado = 1'b1; end
      NP:                  begin teclado_en = 1'b0; display_en = 1'b0; end
      DESTRANCADA, ABERTA: tranca = 1'b0;
      BIPANDO:             begin tranca = 1'b0; bip = 1'b1; end
      SETUP:               begin tranca = 1'b0; setup_on = 1'b1; teclado_en = 1'b0; end
      default:             ;
    endcase
  end

  // Prescaler and seconds counter restart on every state change so each timed state gets whole seconds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      secs  <= '0;
    end else if (next != state) begin
      presc <= '0;
      secs  <= '0;
    end else if (sec_tick) begin
      presc <= '0;
      if (secs != '1) secs <= secs + SEC_W'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entrada   <= VAZIA;
      tent_rest <= TW'(MAX_TENT);
      esc       <= '0;
      flag_cfg  <= 1'b0;
    end else begin
      if (state == TRANCADA && bus.senha_valid) entrada <= bus.senha_in;
      if (state == TRANCADA && botao_config)    flag_cfg <= 1'b1;
      if (next == SETUP && state != SETUP)      flag_cfg <= 1'b0;
      if (state == VALIDAR) begin
        if (match_any) begin
          tent_rest <= TW'(MAX_TENT);
          esc       <= '0;
        end else begin
          tent_rest <= tent_rest - TW'(1);
        end
      end
      // Any way out of lockout restores the attempts; only the timed exit escalates.
      if (state == BLOQUEADO && next != BLOQUEADO) tent_rest <= TW'(MAX_TENT);
      if (state == BLOQUEADO && next == TRANCADA && esc != EW'(MAX_ESC)) esc <= esc + EW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      master <= MASTER_INI;
      cfg    <= CFG_DEFAULT;
      for (int i = 0; i < N_SLOTS; i++) slots[i] <= VAZIA;
    end else if (state == SETUP && bus.cfg_we && bus.cfg_slot <= SW'(N_SLOTS)) begin
      if (bus.cfg_slot == '0 && bus.cfg_senha != VAZIA) master <= bus.cfg_senha;
      for (int i = 0; i < N_SLOTS; i++) begin
        if (bus.cfg_slot == SW'(i + 1)) slots[i] <= bus.cfg_senha;
      end
      cfg <= '{bip_en:      bus.cfg_bip_en,
               bip_time:    no_zero(bus.cfg_bip_time),
               tranca_time: no_zero(bus.cfg_tranca_time)};
    end
  end

endmodule

// File: tb/tb_fechadura_ctrl_n.sv
// tb/tb_fechadura_ctrl_n.sv - directed and randomized bench with a behavioural model of the lock controller
module tb_fechadura_ctrl_n;
  localparam int N_SLOTS  = 4;
  localparam int N_DIG    = 20;
  localparam int MAX_TENT = 5;
  localparam int T_BLOQ_S = 30;
  localparam int MAX_ESC  = 3;
  localparam int TICKS_S  = 10;
  localparam int W        = 4 * N_DIG;

  localparam int L_LOCKED = 0, L_CHECK = 1, L_BLOCK = 2, L_NP = 3;
  localparam int L_UNLOCK = 4, L_OPEN = 5, L_BEEP = 6, L_SETUP = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sensor_contato = 1'b1;
  logic       botao_interno = 1'b0, botao_bloqueio = 1'b0, botao_config = 1'b0;
  logic       tranca, bip, teclado_en, display_en, setup_on, bloqueado;
  logic [2:0] tent_rest;

  always #5 clk = ~clk;

  fechadura_if #(.N_SLOTS(N_SLOTS), .N_DIG(N_DIG)) bus ();

  fechadura_ctrl_n #(
    .N_SLOTS(N_SLOTS), .N_DIG(N_DIG), .MAX_TENT(MAX_TENT),
    .T_BLOQ_S(T_BLOQ_S), .MAX_ESC(MAX_ESC), .TICKS_S(TICKS_S)
  ) dut (
    .clk(clk), .rst(rst), .sensor_contato(sensor_contato),
    .botao_interno(botao_interno), .botao_bloqueio(botao_bloqueio), .botao_config(botao_config),
    .bus(bus),
    .tranca(tranca), .bip(bip), .teclado_en(teclado_en), .display_en(display_en),
    .setup_on(setup_on), .bloqueado(bloqueado), .tent_rest(tent_rest)
  );

  int n_chk = 0;
  int n_pass = 0;

  int           m_mode, m_cyc, m_tent, m_esc, m_bip_t, m_tr_t;
  bit           m_flag, m_bip_en;
  logic [W-1:0] m_entry, m_master;
  logic [W-1:0] m_slot [1:N_SLOTS];

  function automatic logic [W-1:0] pw(input logic [15:0] d);
    return {{(W-16){1'b1}}, d};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = L_LOCKED; m_cyc = 0; m_tent = MAX_TENT; m_esc = 0; m_flag = 0;
    m_entry = '1; m_master = pw(16'h1234);
    for (int i = 1; i <= N_SLOTS; i++) m_slot[i] = '1;
    m_bip_en = 1; m_bip_t = 5; m_tr_t = 5;
  endtask

  function automatic bit m_match(input logic [W-1:0] e);
    if (e == '1) return 0;
    if (e == m_master) return 1;
    for (int i = 1; i <= N_SLOTS; i++) if (m_slot[i] != '1 && m_slot[i] == e) return 1;
    return 0;
  endfunction

  // One clock edge of the specified behaviour; timers are tracked in raw cycles spent in the mode.
  task automatic model_step();
    int nm;
    int s;
    if (rst) begin model_reset(); return; end
    nm = m_mode;
    case (m_mode)
      L_LOCKED: begin
        if (botao_config) m_flag = 1;
        if (botao_interno) nm = L_UNLOCK;
        else if (bus.senha_valid) begin m_entry = bus.senha_in; nm = L_CHECK; end
        else if (botao_bloqueio) nm = L_NP;
      end
      L_CHECK: begin
        if (m_match(m_entry)) begin
          nm = (m_flag && m_entry == m_master) ? L_SETUP : L_UNLOCK;
          m_tent = MAX_TENT; m_esc = 0;
        end else begin
          m_tent--;
          nm = (m_tent == 0) ? L_BLOCK : L_LOCKED;
        end
      end
      L_BLOCK: begin
        if (botao_interno) begin nm = L_UNLOCK; m_tent = MAX_TENT; end
        else if (m_cyc == T_BLOQ_S * (1 << m_esc) * TICKS_S - 1) begin
          nm = L_LOCKED; m_tent = MAX_TENT;
          if (m_esc < MAX_ESC) m_esc++;
        end
      end
      L_NP: begin
        if (botao_interno) nm = L_UNLOCK;
        else if (botao_bloqueio) nm = L_LOCKED;
      end
      L_UNLOCK: begin
        if (!sensor_contato) nm = L_OPEN;
        else if (m_cyc == m_tr_t * TICKS_S - 1) nm = L_LOCKED;
      end
      L_OPEN: begin
        if (sensor_contato) nm = L_UNLOCK;
        else if (m_bip_en && m_cyc == m_bip_t * TICKS_S - 1) nm = L_BEEP;
      end
      L_BEEP: if (sensor_contato) nm = L_UNLOCK;
      default: begin
        s = int'(bus.cfg_slot);
        if (bus.cfg_we && s <= N_SLOTS) begin
          if (s == 0) begin
            if (bus.cfg_senha != '1) m_master = bus.cfg_senha;
          end else m_slot[s] = bus.cfg_senha;
          m_bip_en = bus.cfg_bip_en;
          m_bip_t = (bus.cfg_bip_time == 0) ? 1 : int'(bus.cfg_bip_time);
          m_tr_t = (bus.cfg_tranca_time == 0) ? 1 : int'(bus.cfg_tranca_time);
        end
        if (bus.cfg_done) nm = L_UNLOCK;
      end
    endcase
    if (nm == L_SETUP && m_mode != L_SETUP) m_flag = 0;
    m_cyc = (nm != m_mode) ? 0 : m_cyc + 1;
    m_mode = nm;
  endtask

  task automatic compare_all();
    bit unlocked;
    unlocked = (m_mode == L_UNLOCK || m_mode == L_OPEN || m_mode == L_BEEP || m_mode == L_SETUP);
    chk("tranca", tranca, !unlocked);
    chk("bip", bip, m_mode == L_BEEP);
    chk("teclado_en", teclado_en, !(m_mode == L_BLOCK || m_mode == L_NP || m_mode == L_SETUP));
    chk("display_en", display_en, m_mode != L_NP);
    chk("setup_on", setup_on, m_mode == L_SETUP);
    chk("bloqueado", bloqueado, m_mode == L_BLOCK);
    chk("tent_rest", tent_rest, m_tent);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset(input string p);
    chk({p, "_tranca"}, tranca, 1);
    chk({p, "_bip"}, bip, 0);
    chk({p, "_teclado"}, teclado_en, 1);
    chk({p, "_display"}, display_en, 1);
    chk({p, "_setup"}, setup_on, 0);
    chk({p, "_bloq"}, bloqueado, 0);
    chk({p, "_tent"}, tent_rest, MAX_TENT);
  endtask

  task automatic enter(input logic [W-1:0] p);
    bus.senha_in = p; bus.senha_valid = 1'b1;
    step();
    bus.senha_valid = 1'b0;
    step();
  endtask

  task automatic wait_relock(output int n);
    n = 0;
    while (!tranca && n < 3000) begin step(); n++; end
    chk("relock", tranca, 1);
  endtask

  task automatic lockout_round(input string name, input int exp_cycles);
    int n;
    for (int k = 0; k < MAX_TENT; k++) enter(pw(16'h1111));
    chk({name, "_on"}, bloqueado, 1);
    n = 0;
    while (bloqueado && n < 3000) begin step(); n++; end
    chk(name, n, exp_cycles);
  endtask

  task automatic enter_setup();
    botao_config = 1'b1; step(); botao_config = 1'b0;
    enter(pw(16'h1234));
  endtask

  task automatic async_reset(input string p);
    rst = 1'b1;
    #1;
    check_reset(p);
    model_reset();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    bus.senha_in = '1; bus.senha_valid = 0; bus.cfg_we = 0; bus.cfg_slot = '0;
    bus.cfg_senha = '1; bus.cfg_bip_en = 1; bus.cfg_bip_time = 8'd5;
    bus.cfg_tranca_time = 8'd5; bus.cfg_done = 0;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    step();
    check_reset("reset");

    bus.senha_in = pw(16'h1234); bus.senha_valid = 1'b1;
    step();
    bus.senha_valid = 1'b0;
    chk("tranca_hold", tranca, 1);
    step();
    chk("tranca_fall", tranca, 0);

    sensor_contato = 1'b0;
    n = 0;
    while (!bip && n < 200) begin step(); n++; end
    chk("bip_after_5s", n, 51);
    sensor_contato = 1'b1;
    step();
    chk("bip_off", bip, 0);
    wait_relock(n);
    chk("relock_5s", n, 50);

    enter(pw(16'h1111));
    chk("tent_after_miss", tent_rest, 4);
    enter(pw(16'h1234));
    chk("tent_after_hit", tent_rest, 5);
    wait_relock(n);

    lockout_round("lock30", 300);
    lockout_round("lock60", 600);
    lockout_round("lock120", 1200);
    lockout_round("lock240", 2400);
    lockout_round("lock240_sat", 2400);
    enter(pw(16'h1234));
    wait_relock(n);
    lockout_round("lock30_again", 300);

    enter_setup();
    chk("setup_on", setup_on, 1);
    chk("setup_teclado", teclado_en, 0);
    bus.cfg_we = 1; bus.cfg_slot = 3'd2; bus.cfg_senha = pw(16'h9876);
    bus.cfg_bip_en = 1; bus.cfg_bip_time = 8'd5; bus.cfg_tranca_time = 8'd5; bus.cfg_done = 1;
    step();
    bus.cfg_we = 0; bus.cfg_done = 0;
    chk("write_and_done", setup_on, 0);
    wait_relock(n);
    enter(pw(16'h9876));
    chk("slot2_opens", tranca, 0);
    wait_relock(n);

    enter_setup();
    bus.cfg_we = 1; bus.cfg_slot = 3'd2; bus.cfg_senha = '1;
    step();
    bus.cfg_slot = 3'd0;
    step();
    bus.cfg_slot = 3'd7; bus.cfg_senha = pw(16'h4444); bus.cfg_tranca_time = 8'd1;
    step();
    bus.cfg_we = 0; bus.cfg_tranca_time = 8'd5; bus.cfg_done = 1;
    step();
    bus.cfg_done = 0;
    wait_relock(n);
    chk("oob_write_ignored", n, 50);
    enter(pw(16'h9876));
    chk("slot2_cleared", tranca, 1);
    chk("slot2_cleared_tent", tent_rest, 4);
    enter(pw(16'h1234));
    chk("master_kept", tranca, 0);
    wait_relock(n);

    botao_bloqueio = 1'b1; step(); botao_bloqueio = 1'b0;
    chk("np_teclado", teclado_en, 0);
    chk("np_display", display_en, 0);
    enter(pw(16'h1234));
    chk("np_ignores_entry", tranca, 1);
    botao_interno = 1'b1; step(); botao_interno = 1'b0;
    chk("np_interno", tranca, 0);
    wait_relock(n);

    enter(pw(16'h1111));
    bus.senha_in = pw(16'h1234); bus.senha_valid = 1'b1; botao_interno = 1'b1;
    step();
    bus.senha_valid = 1'b0; botao_interno = 1'b0;
    chk("btn_priority", tranca, 0);
    chk("btn_priority_tent", tent_rest, 4);
    wait_relock(n);

    for (int k = 0; k < 4; k++) enter(pw(16'h2222));
    chk("pre_rst_bloq", bloqueado, 1);
    async_reset("rst_bloq");

    enter_setup();
    bus.cfg_we = 1; bus.cfg_slot = 3'd3; bus.cfg_senha = pw(16'h5555); bus.cfg_tranca_time = 8'd2;
    step();
    bus.cfg_we = 0; bus.cfg_tranca_time = 8'd5;
    chk("pre_rst_setup", setup_on, 1);
    async_reset("rst_setup");
    enter(pw(16'h5555));
    chk("slot_reverted", tranca, 1);
    enter(pw(16'h1234));
    wait_relock(n);
    chk("tranca_time_reverted", n, 50);

    for (int c = 0; c < 5000; c++) begin
      logic [W-1:0] pool [5];
      pool[0] = pw(16'h1234); pool[1] = pw(16'h9876); pool[2] = pw(16'h5555);
      pool[3] = '1; pool[4] = pw(16'($urandom));
      if ($urandom_range(0, 39) == 0) sensor_contato = ~sensor_contato;
      botao_interno  = ($urandom_range(0, 29) == 0);
      botao_bloqueio = ($urandom_range(0, 29) == 0);
      botao_config   = ($urandom_range(0, 19) == 0);
      bus.senha_valid = ($urandom_range(0, 7) == 0);
      bus.senha_in    = pool[$urandom_range(0, 4)];
      bus.cfg_we      = ($urandom_range(0, 3) == 0);
      bus.cfg_slot    = 3'($urandom_range(0, 7));
      bus.cfg_senha   = pool[$urandom_range(0, 4)];
      bus.cfg_bip_en  = ($urandom_range(0, 3) != 0);
      bus.cfg_bip_time = 8'($urandom_range(0, 3));
      bus.cfg_tranca_time = 8'($urandom_range(0, 3));
      bus.cfg_done    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1999) == 0) begin
        rst = 1'b1; model_reset(); step(); rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fechadura_ctrl_n.md
Name: fechadura_ctrl_n

Overview:
Parametrised operational controller for the electronic door lock. It sits between the keypad/digit collector, the setup unit and the lock/buzzer drivers. It supports N password slots plus one master password, escalating lockout after repeated wrong entries, do-not-disturb (NP) mode, an auto-relock timer and a door-open buzzer timer. All timing comes from an internal seconds prescaler.

Parameters:
N_SLOTS, 4, number of user password slots (1..8)
N_DIG, 20, digits per password; BCD nibbles, right-aligned, unused leading digits = 4'hF
MAX_TENT, 5, consecutive wrong entries that trigger lockout
T_BLOQ_S, 30, base lockout time in seconds
MAX_ESC, 3, maximum number of lockout-time doublings
TICKS_S, 1000, clk cycles per second

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
sensor_contato  in  1  1 = door closed
botao_interno  in  1  inside open button; single-cycle pulse
botao_bloqueio  in  1  NP toggle; single-cycle pulse
botao_config  in  1  setup request; single-cycle pulse
senha_in  in  4*N_DIG  entered password
senha_valid  in  1  senha_in valid for one cycle
cfg_we  in  1  setup write strobe; accepted only in SETUP
cfg_slot  in  $clog2(N_SLOTS+1)  0 = master, 1..N_SLOTS = user slot
cfg_senha  in  4*N_DIG  new password; all-F clears the slot (ignored for master)
cfg_bip_en  in  1  buzzer enable
cfg_bip_time  in  8  seconds open before buzzing (1..255; 0 treated as 1)
cfg_tranca_time  in  8  seconds closed-unlocked before relock (0 treated as 1)
cfg_done  in  1  leave SETUP
tranca  out  1  1 = bolt engaged
bip  out  1  buzzer
teclado_en  out  1  keypad enable
display_en  out  1  display enable
setup_on  out  1  SETUP active
bloqueado  out  1  lockout active
tent_rest  out  $clog2(MAX_TENT+1)  remaining attempts

Behaviour:
- Reset values: state TRANCADA, tranca=1, bip=0, teclado_en=1, display_en=1, setup_on=0, bloqueado=0, tent_rest=MAX_TENT. Lockout escalation count=0. Master=...F1234. User slots all-F (disabled). bip_en=1. bip_time=5. tranca_time=5.
- Prescaler: counts to TICKS_S-1 and emits sec_tick. It is cleared on every state entry, so the first second after entry is a full second.
- TRANCADA:
  - senha_valid -> latch senha_in -> VALIDAR.
  - botao_interno -> DESTRANCADA.
  - botao_bloqueio -> NP.
  - botao_config -> latch flag; the next correct master entry goes to SETUP.
  - Priority: botao_interno > senha_valid > botao_bloqueio.
- VALIDAR (1 cycle): compares the latched entry with the master and every enabled slot in parallel.
  - Match: tent_rest=MAX_TENT and escalation count cleared. Goes to SETUP if the config flag is set and the master matched, else DESTRANCADA. tranca falls 2 cycles after the senha_valid cycle.
  - Miss: tent_rest decremented. If it reaches 0 -> BLOQUEADO; else TRANCADA.
- BLOQUEADO:
  - teclado_en=0, bloqueado=1.
  - Duration = T_BLOQ_S << min(esc, MAX_ESC) seconds. On exit esc increments (saturating at MAX_ESC), tent_rest=MAX_TENT, state -> TRANCADA.
  - botao_interno still -> DESTRANCADA; this does not clear esc.
- NP:
  - teclado_en=0, display_en=0, tranca=1.
  - botao_bloqueio -> TRANCADA; botao_interno -> DESTRANCADA.
- DESTRANCADA:
  - tranca=0.
  - sensor_contato=0 -> ABERTA.
  - tranca_time seconds elapsed with the door closed -> TRANCADA.
- ABERTA:
  - tranca=0.
  - Door closed -> DESTRANCADA, timer restarted.
  - bip_time seconds elapsed and bip_en -> BIPANDO.
- BIPANDO: bip=1 until sensor_contato=1 -> DESTRANCADA (bip=0 next cycle).
- SETUP:
  - setup_on=1, tranca=0, teclado_en=0.
  - cfg_we writes the slot and timing fields.
  - cfg_slot > N_SLOTS is ignored.
  - An all-F master write is ignored.
  - cfg_done -> DESTRANCADA.
- rst mid-operation, including during SETUP: all state returns to reset values and the configuration reverts to defaults.
- The all-F entry never matches.
- Simultaneous cfg_we and cfg_done: the write happens, then the exit.

Decomposition:
- Shared package (fechadura_pkg): state enum, senha_t = logic [4*N_DIG-1:0], SENHA_VAZIA constant, MASTER_DEFAULT constant, config struct.
- Sub-module senha_cmp: combinational parallel comparator of one entry against master plus N slots. Outputs match_any and match_master.

Test Plan:
- Reset, then senha_valid with ...F1234 -> tranca 1->0 two cycles later; open door 5 s -> bip=1; close -> bip=0; after 5 s closed -> tranca=1.
- 5 wrong entries -> bloqueado=1 for 30 s. Repeat 5 wrong -> 60 s, then 120, 240, 240 (saturated). Correct entry -> next lockout back to 30 s.
- botao_config, then master entry -> setup_on=1; write slot 2 = ...F9876, cfg_done. Lock, then enter 9876 -> unlock. Write slot 2 all-F -> 9876 rejected.
- botao_bloqueio in TRANCADA -> teclado_en=0, display_en=0, password ignored; botao_interno -> tranca=0.
- Same cycle senha_valid (correct) and botao_interno -> DESTRANCADA via button, tent_rest unchanged.
- rst asserted during BLOQUEADO and during SETUP -> all outputs at reset values immediately; user slots cleared.
